matrix_3x3_win: RTL and testbench

Parametrised 3×3 neighbourhood window generator for the pixel pipeline, sitting between a colour/binarisation stage and any 3×3 kernel (erosion, dilation, Sobel, median). It accepts a raster pixel stream qualified by vsync/href/clken and owns its two line buffers. It emits a 3×3 window with selectable border handling (zero-pad or replicate) plus 2-cycle-delayed sync qualifiers. It generalises the 1-bit window generator to any pixel width and adds line-length overflow detection.

---
 rtl/matrix_3x3_win.sv | 291 +++++++++++++++++++++++++++++
 tb/tb_matrix_3x3_win.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_3x3_win.sv
// ---------------------------------------------------------------------------
// matrix_3x3_win
//
// 3x3 neighbourhood window generator for a raster pixel stream. Two internal
// line buffers hold the previous two lines; a 3x3 register window is shifted
// one column per accepted pixel. Out-of-image neighbours are either zero
// (BORDER_MODE = 0) or replicate the nearest in-image pixel (BORDER_MODE != 0).
//
// Pipeline: stage 1 registers the pixel, line-buffer read data and the
// row/column position; stage 2 updates the window. Every output is 2 clk
// behind its input.
//
// Parameters
//   DATA_W       pixel width in bits
//   IMG_HDISP    active pixels per line (line-buffer depth)
//   IMG_VDISP    active lines per frame (limits how far the row state advances)
//   BORDER_MODE  0 = zero padding, otherwise replicate
//
// Ports
//   clk                 pixel clock
//   rst_n               asynchronous active-low reset
//   per_frame_vsync     frame sync, rising edge starts a frame
//   per_frame_href      line valid
//   per_frame_clken     pixel strobe, pixel accepted when href & clken
//   per_img_data        input pixel
//   matrix_frame_vsync  vsync delayed 2 clk
//   matrix_frame_href   href delayed 2 clk
//   matrix_frame_clken  clken delayed 2 clk, suppressed for dropped pixels
//   matrix_win          {p11,p12,p13,p21,p22,p23,p31,p32,p33}, p33 newest
//   err_ovf             sticky: a line carried more than IMG_HDISP pixels
// ---------------------------------------------------------------------------
module matrix_3x3_win #(
  parameter int DATA_W      = 1,
  parameter int IMG_HDISP   = 1024,
  parameter int IMG_VDISP   = 768,
  parameter int BORDER_MODE = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                per_frame_vsync,
  input  logic                per_frame_href,
  input  logic                per_frame_clken,
  input  logic [DATA_W-1:0]   per_img_data,
  output logic                matrix_frame_vsync,
  output logic                matrix_frame_href,
  output logic                matrix_frame_clken,
  output logic [9*DATA_W-1:0] matrix_win,
  output logic                err_ovf
);

  localparam int  AW   = (IMG_HDISP > 1) ? $clog2(IMG_HDISP) : 1;
  localparam int  CW   = AW + 1;
  localparam bit  REPL = (BORDER_MODE != 0);
  // Highest row state the frame height allows (2 = two lines of history).
  localparam int  ROW_MAX = (IMG_VDISP >= 3) ? 2 : ((IMG_VDISP == 2) ? 1 : 0);

  typedef enum logic [1:0] {
    ROW0 = 2'd0,
    ROW1 = 2'd1,
    ROWN = 2'd2
  } row_e;

  // Input edge detection
  logic vsync_prev_r;
  logic href_prev_r;
  logic vsync_rise_s;
  logic href_rise_s;
  logic href_fall_s;

  // Position tracking
  row_e            row_r;
  row_e            row_nxt_s;
  row_e            row_eff_s;
  logic [CW-1:0]   col_r;
  logic [CW-1:0]   col_eff_s;
  logic [CW-1:0]   col_nxt_s;
  logic            accept_s;
  logic            ovf_s;
  logic            wr_s;
  logic [AW-1:0]   addr_s;

  // Line buffers
  logic [DATA_W-1:0] lb1_mem [IMG_HDISP];
  logic [DATA_W-1:0] lb2_mem [IMG_HDISP];

  // Stage 1
  logic              vsync_d1_r;
  logic              href_d1_r;
  logic              clken_d1_r;
  logic              s1_valid_r;
  logic              s1_col0_r;
  row_e              s1_row_r;
  logic [DATA_W-1:0] s1_pix_r;
  logic [DATA_W-1:0] lb1_q_r;
  logic [DATA_W-1:0] lb2_q_r;

  // Stage 2 window, [row][col]: row 0 = top (p1x), col 0 = oldest (px1)
  logic [DATA_W-1:0] win_r     [3][3];
  logic [DATA_W-1:0] win_nxt_s [3][3];
  logic [DATA_W-1:0] new_col_s [3];
  logic [9*DATA_W-1:0] win_pack_s;

  assign vsync_rise_s = per_frame_vsync & ~vsync_prev_r;
  assign href_rise_s  = per_frame_href  & ~href_prev_r;
  assign href_fall_s  = ~per_frame_href & href_prev_r;
  assign accept_s     = per_frame_href  & per_frame_clken;

  // Current pixel position: a same-cycle href/vsync rise applies first.
  always_comb begin
    col_eff_s = col_r;
    row_eff_s = row_r;
    if (href_rise_s) begin
      col_eff_s = {CW{1'b0}};
    end else begin
      col_eff_s = col_r;
    end
    if (vsync_rise_s) begin
      row_eff_s = ROW0;
    end else begin
      row_eff_s = row_r;
    end
  end

  assign ovf_s  = accept_s & (col_eff_s >= CW'(IMG_HDISP));
  assign wr_s   = accept_s & ~ovf_s;
  assign addr_s = col_eff_s[AW-1:0];

  // Column counter next value; saturates so an overlong line never wraps
  // back into the valid address range.
  always_comb begin
    col_nxt_s = col_eff_s;
    if (accept_s) begin
      if (col_eff_s == {CW{1'b1}}) begin
        col_nxt_s = col_eff_s;
      end else begin
        col_nxt_s = col_eff_s + CW'(1);
      end
    end else begin
      col_nxt_s = col_eff_s;
    end
  end

  // Row state next value: cleared by vsync, advanced by each line end.
  always_comb begin
    row_nxt_s = row_r;
    if (vsync_rise_s) begin
      row_nxt_s = ROW0;
    end else if (href_fall_s) begin
      case (row_r)
        ROW0:    row_nxt_s = (ROW_MAX >= 1) ? ROW1 : ROW0;
        ROW1:    row_nxt_s = (ROW_MAX >= 2) ? ROWN : ROW1;
        ROWN:    row_nxt_s = ROWN;
        default: row_nxt_s = ROW0;
      endcase
    end else begin
      row_nxt_s = row_r;
    end
  end

  // Edge history, position counters and the sticky overflow flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_prev_r <= 1'b0;
      href_prev_r  <= 1'b0;
      row_r        <= ROW0;
      col_r        <= {CW{1'b0}};
      err_ovf      <= 1'b0;
    end else begin
      vsync_prev_r <= per_frame_vsync;
      href_prev_r  <= per_frame_href;
      row_r        <= row_nxt_s;
      col_r        <= col_nxt_s;
      err_ovf      <= (err_ovf & ~vsync_rise_s) | ovf_s;
    end
  end

  // Line-buffer RAMs: LB1 takes the new pixel, LB2 takes LB1's old word at
  // the same address, so LB1 holds line r-1 and LB2 line r-2.
  always_ff @(posedge clk) begin
    if (wr_s) begin
      lb1_mem[addr_s] <= per_img_data;
      lb2_mem[addr_s] <= lb1_mem[addr_s];
    end
  end

  // Stage 1: sync delays, pixel, RAM read data and position flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_d1_r <= 1'b0;
      href_d1_r  <= 1'b0;
      clken_d1_r <= 1'b0;
      s1_valid_r <= 1'b0;
      s1_col0_r  <= 1'b0;
      s1_row_r   <= ROW0;
      s1_pix_r   <= {DATA_W{1'b0}};
      lb1_q_r    <= {DATA_W{1'b0}};
      lb2_q_r    <= {DATA_W{1'b0}};
    end else begin
      vsync_d1_r <= per_frame_vsync;
      href_d1_r  <= per_frame_href;
      clken_d1_r <= per_frame_clken & ~ovf_s;
      s1_valid_r <= wr_s;
      if (wr_s) begin
        s1_col0_r <= (col_eff_s == {CW{1'b0}});
        s1_row_r  <= row_eff_s;
        s1_pix_r  <= per_img_data;
        lb1_q_r   <= lb1_mem[addr_s];
        lb2_q_r   <= lb2_mem[addr_s];
      end
    end
  end

  // New window column (top, mid, bottom). Line-buffer data is only used once
  // the row state says that line exists, which masks stale RAM contents.
  always_comb begin
    new_col_s[0] = {DATA_W{1'b0}};
    new_col_s[1] = {DATA_W{1'b0}};
    new_col_s[2] = s1_pix_r;
    case (s1_row_r)
      ROW0: begin
        new_col_s[0] = REPL ? s1_pix_r : {DATA_W{1'b0}};
        new_col_s[1] = REPL ? s1_pix_r : {DATA_W{1'b0}};
      end
      ROW1: begin
        new_col_s[0] = REPL ? lb1_q_r : {DATA_W{1'b0}};
        new_col_s[1] = lb1_q_r;
      end
      ROWN: begin
        new_col_s[0] = lb2_q_r;
        new_col_s[1] = lb1_q_r;
      end
      default: begin
        new_col_s[0] = {DATA_W{1'b0}};
        new_col_s[1] = {DATA_W{1'b0}};
      end
    endcase
  end

  // Window next state: column 0 restarts the window, otherwise shift left.
  always_comb begin
    win_nxt_s = win_r;
    if (s1_valid_r) begin
      for (int i = 0; i < 3; i++) begin
        if (s1_col0_r) begin
          win_nxt_s[i][0] = REPL ? new_col_s[i] : {DATA_W{1'b0}};
          win_nxt_s[i][1] = REPL ? new_col_s[i] : {DATA_W{1'b0}};
          win_nxt_s[i][2] = new_col_s[i];
        end else begin
          win_nxt_s[i][0] = win_r[i][1];
          win_nxt_s[i][1] = win_r[i][2];
          win_nxt_s[i][2] = new_col_s[i];
        end
      end
    end else begin
      win_nxt_s = win_r;
    end
  end

  // Flatten the window: p11 in the MSBs down to p33 in the LSBs.
  always_comb begin
    win_pack_s = {(9*DATA_W){1'b0}};
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        win_pack_s[(8 - (3*i + j))*DATA_W +: DATA_W] = win_nxt_s[i][j];
      end
    end
  end

  // Stage 2: window state and registered outputs; the window output reads
  // zero whenever the delayed href is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) begin
        for (int j = 0; j < 3; j++) begin
          win_r[i][j] <= {DATA_W{1'b0}};
        end
      end
      matrix_frame_vsync <= 1'b0;
      matrix_frame_href  <= 1'b0;
      matrix_frame_clken <= 1'b0;
      matrix_win         <= {(9*DATA_W){1'b0}};
    end else begin
      win_r              <= win_nxt_s;
      matrix_frame_vsync <= vsync_d1_r;
      matrix_frame_href  <= href_d1_r;
      matrix_frame_clken <= clken_d1_r;
      matrix_win         <= href_d1_r ? win_pack_s : {(9*DATA_W){1'b0}};
    end
  end

endmodule

// File: tb/tb_matrix_3x3_win.sv
// Bench for matrix_3x3_win: two instances (zero-pad and replicate) share one
// stimulus stream. A reference model computes every expected window directly
// from the stored image with clamp/zero border rules.
module tb_matrix_3x3_win;

  localparam int DW = 8;
  localparam int HD = 4;

  logic clk;
  logic rst_n;
  logic vs, hr, ck;
  logic [DW-1:0] dat;

  logic mv0, mh0, mc0, err0;
  logic mv1, mh1, mc1, err1;
  logic [9*DW-1:0] mw0, mw1;

  matrix_3x3_win #(.DATA_W(DW), .IMG_HDISP(HD), .IMG_VDISP(3), .BORDER_MODE(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n),
    .per_frame_vsync(vs), .per_frame_href(hr), .per_frame_clken(ck), .per_img_data(dat),
    .matrix_frame_vsync(mv0), .matrix_frame_href(mh0), .matrix_frame_clken(mc0),
    .matrix_win(mw0), .err_ovf(err0)
  );

  matrix_3x3_win #(.DATA_W(DW), .IMG_HDISP(HD), .IMG_VDISP(3), .BORDER_MODE(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .per_frame_vsync(vs), .per_frame_href(hr), .per_frame_clken(ck), .per_img_data(dat),
    .matrix_frame_vsync(mv1), .matrix_frame_href(mh1), .matrix_frame_clken(mc1),
    .matrix_win(mw1), .err_ovf(err1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    int           r;
    int           c;
    logic [71:0]  w0;
    logic [71:0]  w1;
    int           cyc;
  } exp_t;

  typedef struct {
    string        name;
    int           mode;
    int           r;
    int           c;
    logic [71:0]  exp;
  } vec_t;

  exp_t q[$];
  exp_t mon_e;
  vec_t tbl [6];

  logic [7:0]  img  [3][8];
  logic [71:0] cap0 [3][4];
  logic [71:0] cap1 [3][4];

  logic drv_drop;
  logic drv_ckexp;
  logic hv0, hv1, hh0, hh1, hc0, hc1;
  logic err_m, prev_vs;
  logic [71:0] last0, last1;
  int pulses;

  task automatic chk1(input string nm, input logic got, input logic exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  task automatic chkw(input string nm, input logic [71:0] got, input logic [71:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  task automatic chki(input string nm, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  // Neighbour value with border rule; only negative indices can occur.
  function automatic logic [7:0] nb(input int mode, input int r, input int c);
    if (r < 0 || c < 0) begin
      if (mode == 0) return 8'h00;
      return img[(r < 0) ? 0 : r][(c < 0) ? 0 : c];
    end
    return img[r][c];
  endfunction

  function automatic logic [71:0] win_exp(input int mode, input int r, input int c);
    logic [71:0] w;
    w = 72'd0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        w[(8 - (3*i + j))*8 +: 8] = nb(mode, r - 2 + i, c - 2 + j);
    return w;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      vs = 1'b0; hr = 1'b0; ck = 1'b0; drv_drop = 1'b0; drv_ckexp = 1'b0;
      step();
    end
  endtask

  task automatic drive_pix(input int r, input int c, input logic [7:0] d);
    exp_t e;
    img[r][c] = d;
    hr = 1'b1; ck = 1'b1; dat = d;
    if (c < HD) begin
      e.r = r; e.c = c; e.cyc = cyc;
      e.w0 = win_exp(0, r, c);
      e.w1 = win_exp(1, r, c);
      q.push_back(e);
      drv_drop = 1'b0;
    end else begin
      drv_drop = 1'b1;
    end
    drv_ckexp = ~drv_drop;
    step();
  endtask

  task automatic vsync_pulse();
    hr = 1'b0; ck = 1'b0; drv_drop = 1'b0; drv_ckexp = 1'b0;
    vs = 1'b1; step(); step();
    vs = 1'b0; step(); step();
  endtask

  task automatic frame(input bit gaps, input bit rnd, input int len0);
    int len;
    pulses = 0;
    vsync_pulse();
    for (int r = 0; r < 3; r++) begin
      len = (r == 0) ? len0 : HD;
      for (int c = 0; c < len; c++) begin
        if (gaps) begin
          for (int g = 0; g < 6 && $urandom_range(0, 1) == 0; g++) begin
            hr = 1'b1; ck = 1'b0; drv_drop = 1'b0; drv_ckexp = 1'b0;
            step();
          end
        end
        drive_pix(r, c, rnd ? 8'($urandom) : 8'(16*(r+1) + (c+1)));
      end
      idle(3);
    end
    idle(2);
  endtask

  task automatic clear_caps();
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 4; c++) begin
        cap0[r][c] = 72'd0;
        cap1[r][c] = 72'd0;
      end
  endtask

  task automatic run_table();
    for (int i = 0; i < 6; i++)
      chkw(tbl[i].name, (tbl[i].mode != 0) ? cap1[tbl[i].r][tbl[i].c] : cap0[tbl[i].r][tbl[i].c],
           tbl[i].exp);
  endtask

  task automatic frame_end_checks(input string nm);
    chki({nm, "_pulses"}, pulses, 12);
    chki({nm, "_pending"}, q.size(), 0);
  endtask

  task automatic check_all_zero(input string nm);
    chkw({nm, "_win0"}, mw0, 72'd0);
    chkw({nm, "_win1"}, mw1, 72'd0);
    chk1({nm, "_href"}, mh1 | mh0, 1'b0);
    chk1({nm, "_clken"}, mc1 | mc0, 1'b0);
    chk1({nm, "_vsync"}, mv1 | mv0, 1'b0);
    chk1({nm, "_err"}, err1 | err0, 1'b0);
  endtask

  // Monitor: sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      {hv1, hv0, hh1, hh0, hc1, hc0} = 6'd0;
      err_m = 1'b0; prev_vs = 1'b0;
      last0 = 72'd0; last1 = 72'd0;
      q.delete();
    end else begin
      chk1("vsync_dly1", mv1, hv1);
      chk1("vsync_dly0", mv0, hv1);
      chk1("href_dly1", mh1, hh1);
      chk1("href_dly0", mh0, hh1);
      chk1("clken_dly1", mc1, hc1);
      chk1("clken_dly0", mc0, hc1);
      chk1("err_ovf1", err1, err_m);
      chk1("err_ovf0", err0, err_m);
      if (mh1 && mc1) begin
        if (q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL unexpected_pulse: got pulse expected none (cycle %0d)", cyc);
        end else begin
          mon_e = q.pop_front();
          chkw("win_mode0", mw0, mon_e.w0);
          chkw("win_mode1", mw1, mon_e.w1);
          chki("latency", cyc, mon_e.cyc + 2);
          cap0[mon_e.r][mon_e.c] = mw0;
          cap1[mon_e.r][mon_e.c] = mw1;
          last0 = mw0; last1 = mw1;
          pulses++;
        end
      end else if (mh1) begin
        chkw("hold_mode0", mw0, last0);
        chkw("hold_mode1", mw1, last1);
      end else begin
        chkw("zero_mode0", mw0, 72'd0);
        chkw("zero_mode1", mw1, 72'd0);
      end
      err_m   = (err_m & ~(vs & ~prev_vs)) | drv_drop;
      prev_vs = vs;
      hv1 = hv0; hv0 = vs;
      hh1 = hh0; hh0 = hr;
      hc1 = hc0; hc0 = drv_ckexp;
    end
  end

  initial begin
    tbl[0] = '{"m1_p23", 1, 2, 3, 72'h12_13_14_22_23_24_32_33_34};
    tbl[1] = '{"m1_p11", 1, 1, 1, 72'h11_11_12_11_11_12_21_21_22};
    tbl[2] = '{"m1_p00", 1, 0, 0, 72'h11_11_11_11_11_11_11_11_11};
    tbl[3] = '{"m0_p11", 0, 1, 1, 72'h00_00_00_00_11_12_00_21_22};
    tbl[4] = '{"m0_p00", 0, 0, 0, 72'h00_00_00_00_00_00_00_00_11};
    tbl[5] = '{"m0_p23", 0, 2, 3, 72'h12_13_14_22_23_24_32_33_34};

    rst_n = 1'b0; vs = 1'b0; hr = 1'b0; ck = 1'b0; dat = 8'h00;
    drv_drop = 1'b0; drv_ckexp = 1'b0; pulses = 0;
    clear_caps();
    step(); step(); step();
    check_all_zero("reset");
    rst_n = 1'b1;
    idle(3);

    // Continuous clken, formula image
    frame(1'b0, 1'b0, HD);
    frame_end_checks("cont");
    run_table();

    // Random gaps inside href, same image
    clear_caps();
    frame(1'b1, 1'b0, HD);
    frame_end_checks("gaps");
    run_table();

    // Overlong line 0: pixels 4 and 5 dropped, err_ovf sticky
    clear_caps();
    frame(1'b0, 1'b0, 6);
    frame_end_checks("ovf");
    chk1("ovf_sticky", err1, 1'b1);
    clear_caps();
    frame(1'b0, 1'b0, HD);
    frame_end_checks("after_ovf");
    chk1("ovf_cleared", err1, 1'b0);
    run_table();

    // Random data with gaps
    for (int f = 0; f < 3; f++) begin
      frame(1'b1, 1'b1, HD);
      frame_end_checks("rand");
    end

    // Reset asserted mid-row 1 of a frame with random data
    vsync_pulse();
    for (int c = 0; c < HD; c++) drive_pix(0, c, 8'($urandom));
    idle(3);
    drive_pix(1, 0, 8'($urandom));
    drive_pix(1, 1, 8'($urandom));
    hr = 1'b1; ck = 1'b0; drv_ckexp = 1'b0; drv_drop = 1'b0;
    step();
    rst_n = 1'b0;
    #1;
    check_all_zero("async_rst");
    idle(3);
    rst_n = 1'b1;
    idle(2);
    clear_caps();
    frame(1'b0, 1'b0, HD);
    frame_end_checks("post_rst");
    chkw("post_rst_m1_p11", cap1[1][1], tbl[1].exp);
    chkw("post_rst_m0_p11", cap0[1][1], tbl[3].exp);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
